uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_rcv.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rcv.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// ---------------------------------------------------------------------------
// uart_rcv -- 8N1 asynchronous serial receiver
//
// Purpose:
//   Receives LSB-first frames (1 start, 8 data, 1 stop, no parity) on an
//   asynchronous line. The line is brought into the clk domain through a
//   two-flop synchronizer. A start is recognised on a falling edge of the
//   synchronized line. Each bit is then sampled at its middle, using a
//   down-counter that is first loaded with half a bit period and afterwards
//   with a full bit period.
//
// Parameters:
//   BAUD_DIV   clk cycles per serial bit (default 2604 = 50 MHz / 19200 baud)
//
// Ports:
//   clk        system clock, all flops on the rising edge
//   rst        synchronous active-high reset
//   RX         asynchronous serial input, idles high
//   clr_rdy    consumer acknowledge; clears rdy
//   rx_data    last received byte (held until the next complete frame)
//   rdy        set when a frame completes; cleared by clr_rdy or a new start
//   frm_err    stop bit of the last frame was sampled low; valid while rdy=1
// ---------------------------------------------------------------------------
module uart_rcv #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;

    localparam logic [CNT_W-1:0] C_HALF   = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    // Sample index of the start bit and of the stop bit (0-based).
    localparam logic [3:0] C_START_IDX = 4'd0;
    localparam logic [3:0] C_STOP_IDX  = 4'd9;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RECEIVE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic             r_rx_meta;     // first synchronizer stage
    logic             r_rx_s;        // synchronized line (rx_s)
    logic [1:0]       r_sync_fill;   // tracks when r_rx_s holds a real sample
    logic             r_rx_prev;     // previous real sample, 0 until line seen high

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_shift;

    logic [7:0]       r_rx_data;
    logic             r_rdy;
    logic             r_frm_err;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    state_t           w_state_nxt;
    logic             w_start;       // falling edge seen while idle
    logic             w_sample;      // mid-bit sample point
    logic             w_false_start; // start bit read back high -> abandon
    logic             w_frame_done;  // stop bit sampled

    // -----------------------------------------------------------------------
    // Input synchronizer and edge-detect history
    //
    // Both stages reset to 1, so for two cycles after reset r_rx_s shows the
    // reset value rather than the line. r_sync_fill marks when the pipeline
    // holds genuine samples. r_rx_prev only records a 1 once the line has
    // really been seen high. With RX held low through reset release, no
    // falling edge can be detected until the line rises and falls again.
    // -----------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // flops update together from pre-edge values; blocking assignments here
    // would make the result depend on statement and process ordering.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (checked inside the clocked block),
        // so it only takes effect on a rising clk edge.
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_sync_fill <= 2'b00;
            r_rx_prev   <= 1'b0;
        end else begin
            r_rx_meta   <= RX;
            r_rx_s      <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_rx_prev   <= r_sync_fill[1] & r_rx_s;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_sample      = 1'b0;
        w_false_start = 1'b0;
        w_frame_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RECEIVE;
                end
            end

            S_RECEIVE: begin
                if (r_baud_cnt == '0) begin
                    w_sample = 1'b1;
                    if ((r_bit_cnt == C_START_IDX) && r_rx_s) begin
                        // The low pulse was shorter than half a bit: treat it
                        // as a glitch and go back to idle.
                        w_false_start = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else if (r_bit_cnt == C_STOP_IDX) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit timing and shift register
    //
    // The counter is loaded with half a bit at start detect and counts down
    // to zero. Each sample reloads a full bit, so every sample lands mid-bit.
    // While idle the counter holds its value.
    // Bits enter the shift register at the MSB. When the stop bit is sampled,
    // the register holds {D7..D0, start}, and the byte is r_shift[8:1].
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= C_HALF;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 9'd0;
        end else if (w_start) begin
            r_baud_cnt <= C_HALF;
            r_bit_cnt  <= 4'd0;
        end else if (w_sample) begin
            r_baud_cnt <= C_RELOAD;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_shift    <= {r_rx_s, r_shift[8:1]};
        end else if (r_state == S_RECEIVE) begin
            r_baud_cnt <= r_baud_cnt - C_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    //
    // rx_data and frm_err change only when a frame completes, including a
    // frame with a bad stop bit. A false start leaves all outputs untouched.
    // When a frame completes in the same cycle clr_rdy is high, rdy is still
    // set, so the completed byte is never lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_frm_err <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_rx_data <= r_shift[8:1];
                r_frm_err <= ~r_rx_s;
            end

            if (w_frame_done) begin
                r_rdy <= 1'b1;
            end else if (w_start || clr_rdy) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;
    assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rcv.sv
// ---------------------------------------------------------------------------
// tb_uart_rcv -- self-checking bench for uart_rcv
//
// Stimulus threads drive serial frames on RX. Each expected byte and framing
// flag goes into a scoreboard queue as its frame is issued. An independent
// monitor pops one entry for every rising edge of rdy and compares it with
// rx_data/frm_err. Directed checks cover reset, glitch rejection, back-to-back
// frames, reset during a frame, and clr_rdy colliding with a frame completing.
// A short bit period keeps the run short.
// ---------------------------------------------------------------------------
module tb_uart_rcv;

    localparam int BAUD = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic mon_prev_rdy;

    int   lat_a;
    bit   found_a;
    bit   found_b;
    bit   found_c;

    uart_rcv #(.BAUD_DIV(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives the first nbits of a frame {stop, d[7:0], start}, one bit per
    // BAUD cycles. Inputs change on negedges, away from the sampling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int nbits);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            RX = f[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_b;
        sb_q.push_back(e);
        send_frame(d, stop_b, 10);
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        repeat (n * BAUD) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial mon_prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (rdy === 1'b1 && mon_prev_rdy !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rdy", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rx_data", 32'(rx_data), 32'(e.data));
                check("sb_frm_err", 32'(frm_err), 32'(e.ferr));
            end
        end
        mon_prev_rdy <= rdy;
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        checks  = 0;
        errors  = 0;
        RX      = 1'b1;
        rst     = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_rdy",     32'(rdy),     32'd0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_frm_err", 32'(frm_err), 32'd0);

        rst = 1'b0;
        idle_bits(2);

        // 8'hA5 with a good stop bit, and latency from the falling edge to rdy.
        fork
            send_byte(8'hA5, 1'b1);
            begin
                found_a = 1'b0;
                lat_a   = 0;
                for (int i = 1; i <= 200 && !found_a; i++) begin
                    @(negedge clk);
                    if (rdy) begin
                        found_a = 1'b1;
                        lat_a   = i;
                    end
                end
                check("a5_rdy_seen", 32'(found_a), 32'd1);
                check("a5_latency_window",
                      32'((lat_a >= 154) && (lat_a <= 158)), 32'd1);
            end
        join
        idle_bits(1);
        check("a5_rdy_held", 32'(rdy), 32'd1);
        pulse_clr();
        check("a5_rdy_cleared", 32'(rdy), 32'd0);

        // 8'h3C with the stop bit forced low.
        send_byte(8'h3C, 1'b0);
        idle_bits(2);
        check("ferr_rdy",     32'(rdy),     32'd1);
        check("ferr_frm_err", 32'(frm_err), 32'd1);
        pulse_clr();
        check("ferr_stable_after_clr", 32'(frm_err), 32'd1);

        // Low pulse shorter than half a bit: rejected as a false start.
        RX = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(3);
        check("glitch_no_rdy",    32'(rdy),     32'd0);
        check("glitch_data_hold", 32'(rx_data), 32'h3C);
        check("glitch_ferr_hold", 32'(frm_err), 32'd1);

        // 8'h00 then 8'hFF with no idle bits between, clr_rdy in between.
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
            end
            begin
                found_b = 1'b0;
                for (int i = 0; i < 200 && !found_b; i++) begin
                    @(negedge clk);
                    if (rdy) found_b = 1'b1;
                end
                check("b2b_first_rdy", 32'(found_b), 32'd1);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
                repeat (60) @(negedge clk);
                check("b2b_rdy_low_in_frame2", 32'(rdy), 32'd0);
            end
        join
        idle_bits(1);
        check("b2b_second_rdy", 32'(rdy),     32'd1);
        check("b2b_second_data", 32'(rx_data), 32'hFF);
        pulse_clr();

        // Reset during bit 4 of an 8'h55 frame, with RX held low through and
        // after release: no reception until the line rises and falls again.
        send_frame(8'h55, 1'b1, 5);
        RX  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_rdy",     32'(rdy),     32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        repeat (12 * BAUD) @(negedge clk);
        check("rx_low_after_rst_no_rdy", 32'(rdy),     32'd0);
        check("rx_low_after_rst_data",   32'(rx_data), 32'h00);
        idle_bits(2);
        send_byte(8'h81, 1'b1);
        idle_bits(1);
        check("post_rst_rdy", 32'(rdy), 32'd1);
        pulse_clr();

        // clr_rdy held high across the cycle in which rdy is set: set wins,
        // then the following clr_rdy cycle clears it.
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (150) @(negedge clk);
                clr_rdy = 1'b1;
                found_c = 1'b0;
                for (int i = 0; i < 20 && !found_c; i++) begin
                    @(negedge clk);
                    if (rdy) found_c = 1'b1;
                end
                check("set_wins_over_clr", 32'(found_c), 32'd1);
                @(negedge clk);
                check("clr_after_set", 32'(rdy), 32'd0);
                clr_rdy = 1'b0;
            end
        join
        idle_bits(2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
